// File: rtl/shared_mem_mc.sv
// rtl/shared_mem_mc.sv - multi-channel shared buffer RAM with per-channel circular FIFOs
module shared_mem_mc #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  hclk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_mode,
  input  logic [CW-1:0]         ahb_ch,
  input  logic                  ahb_wr_en,
  input  logic [DATA_WIDTH-1:0] ahb_wdata,
  input  logic                  ahb_rd_en,
  output logic [DATA_WIDTH-1:0] ahb_rdata,
  output logic                  ahb_rvalid,
  output logic [AW:0]           ahb_level,
  input  logic [CW-1:0]         phy_ch,
  input  logic                  phy_we,
  input  logic [DATA_WIDTH-1:0] phy_wdata,
  input  logic                  phy_re,
  output logic [DATA_WIDTH-1:0] phy_rdata,
  output logic                  phy_rvalid,
  input  logic                  size_wr,
  input  logic [CW-1:0]         size_ch,
  input  logic [AW:0]           size_val,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     done_irq,
  output logic [NUM_CH-1:0]     ovf_err,
  output logic [NUM_CH-1:0]     udf_err,
  input  logic [NUM_CH-1:0]     irq_clr
);

  localparam int          MEM_WORDS = 1 << (CW + AW);
  localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW + 1)'(1);

  logic [AW-1:0]         wptr     [NUM_CH];
  logic [AW-1:0]         rptr     [NUM_CH];
  logic [AW:0]           count    [NUM_CH];
  logic [AW:0]           xfer_cnt [NUM_CH];
  logic [AW:0]           size_q   [NUM_CH];
  logic [NUM_CH-1:0]     mode_q;
  logic [DATA_WIDTH-1:0] mem      [MEM_WORDS];

  logic [NUM_CH-1:0] ahb_sel, phy_sel, flush;
  logic [NUM_CH-1:0] push_req, pop_req, push_ok, pop_ok, phy_op, done_set;
  logic              ahb_push, ahb_pop, phy_push, phy_pop;
  logic [AW-1:0]     ahb_wptr, ahb_rptr, phy_wptr, phy_rptr;

  // Per-channel decode: TX channels are fed by AHB and drained by PHY, RX the reverse.
  // A channel whose mode bit just changed is flushed, so its requests are masked.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ahb_sel[g]  = (ahb_ch == CW'(g));
    assign phy_sel[g]  = (phy_ch == CW'(g));
    assign flush[g]    = ch_mode[g] ^ mode_q[g];
    assign full[g]     = (count[g] == FULL_CNT);
    assign empty[g]    = (count[g] == '0);
    assign push_req[g] = !flush[g] && (mode_q[g] ? (ahb_wr_en && ahb_sel[g])
                                                 : (phy_we && phy_sel[g]));
    assign pop_req[g]  = !flush[g] && (mode_q[g] ? (phy_re && phy_sel[g])
                                                 : (ahb_rd_en && ahb_sel[g]));
    assign push_ok[g]  = push_req[g] && !full[g];
    assign pop_ok[g]   = pop_req[g] && !empty[g];
    assign phy_op[g]   = mode_q[g] ? pop_ok[g] : push_ok[g];
    assign done_set[g] = phy_op[g] && (size_q[g] != '0) &&
                         ((xfer_cnt[g] + ONE_CNT) == size_q[g]);
  end

  // Route the selected channel's pointers and accept strobes onto each side.
  always_comb begin
    ahb_wptr  = '0;
    ahb_rptr  = '0;
    ahb_level = '0;
    ahb_push  = 1'b0;
    ahb_pop   = 1'b0;
    phy_wptr  = '0;
    phy_rptr  = '0;
    phy_push  = 1'b0;
    phy_pop   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ahb_sel[i]) begin
        ahb_wptr  = wptr[i];
        ahb_rptr  = rptr[i];
        ahb_level = count[i];
        ahb_push  = push_ok[i] && mode_q[i];
        ahb_pop   = pop_ok[i] && !mode_q[i];
      end
      if (phy_sel[i]) begin
        phy_wptr = wptr[i];
        phy_rptr = rptr[i];
        phy_push = push_ok[i] && !mode_q[i];
        phy_pop  = pop_ok[i] && mode_q[i];
      end
    end
  end

  // Buffer RAM writes; the two sides never target the same channel's producer slot.
  always_ff @(posedge hclk) begin
    if (ahb_push) mem[{ahb_ch, ahb_wptr}] <= ahb_wdata;
    if (phy_push) mem[{phy_ch, phy_wptr}] <= phy_wdata;
  end

  // Registered read ports; rdata holds its last popped word when no pop is accepted.
  always_ff @(posedge hclk) begin
    if (reset) begin
      ahb_rdata  <= '0;
      ahb_rvalid <= 1'b0;
      phy_rdata  <= '0;
      phy_rvalid <= 1'b0;
    end else begin
      ahb_rvalid <= ahb_pop;
      phy_rvalid <= phy_pop;
      if (ahb_pop) ahb_rdata <= mem[{ahb_ch, ahb_rptr}];
      if (phy_pop) phy_rdata <= mem[{phy_ch, phy_rptr}];
    end
  end

  // Channel bookkeeping: pointers, occupancy, transfer counting and sticky flags.
  always_ff @(posedge hclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        count[i]    <= '0;
        xfer_cnt[i] <= '0;
        size_q[i]   <= '0;
        mode_q[i]   <= 1'b0;
        done_irq[i] <= 1'b0;
        ovf_err[i]  <= 1'b0;
        udf_err[i]  <= 1'b0;
      end else begin
        if (flush[i]) begin
          wptr[i]     <= '0;
          rptr[i]     <= '0;
          count[i]    <= '0;
          xfer_cnt[i] <= '0;
          mode_q[i]   <= ch_mode[i];
        end else begin
          if (push_ok[i]) wptr[i] <= wptr[i] + AW'(1);
          if (pop_ok[i])  rptr[i] <= rptr[i] + AW'(1);
          case ({push_ok[i], pop_ok[i]})
            2'b10:   count[i] <= count[i] + ONE_CNT;
            2'b01:   count[i] <= count[i] - ONE_CNT;
            default: count[i] <= count[i];
          endcase
          if (phy_op[i] && (size_q[i] != '0))
            xfer_cnt[i] <= done_set[i] ? '0 : xfer_cnt[i] + ONE_CNT;
        end
        // Reprogramming the size restarts the transfer count.
        if (size_wr && (size_ch == CW'(i))) begin
          size_q[i]   <= size_val;
          xfer_cnt[i] <= '0;
        end
        // A new event in the same cycle as its clear keeps the flag set.
        done_irq[i] <= (done_irq[i] && !irq_clr[i]) || done_set[i];
        ovf_err[i]  <= (ovf_err[i] && !irq_clr[i]) || (push_req[i] && full[i]);
        udf_err[i]  <= (udf_err[i] && !irq_clr[i]) || (pop_req[i] && empty[i]);
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_mc.sv
// tb/tb_shared_mem_mc.sv - self-checking bench for shared_mem_mc
module tb_shared_mem_mc;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int DEP = 256;
  localparam int AW  = 8;
  localparam int CW  = 2;

  logic           hclk, reset;
  logic [NCH-1:0] ch_mode;
  logic [CW-1:0]  ahb_ch, phy_ch, size_ch;
  logic           ahb_wr_en, ahb_rd_en, ahb_rvalid;
  logic [DW-1:0]  ahb_wdata, ahb_rdata;
  logic [AW:0]    ahb_level, size_val;
  logic           phy_we, phy_re, phy_rvalid, size_wr;
  logic [DW-1:0]  phy_wdata, phy_rdata;
  logic [NCH-1:0] full, empty, done_irq, ovf_err, udf_err, irq_clr;

  shared_mem_mc #(.NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .hclk(hclk), .reset(reset), .ch_mode(ch_mode),
    .ahb_ch(ahb_ch), .ahb_wr_en(ahb_wr_en), .ahb_wdata(ahb_wdata), .ahb_rd_en(ahb_rd_en),
    .ahb_rdata(ahb_rdata), .ahb_rvalid(ahb_rvalid), .ahb_level(ahb_level),
    .phy_ch(phy_ch), .phy_we(phy_we), .phy_wdata(phy_wdata), .phy_re(phy_re),
    .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid),
    .size_wr(size_wr), .size_ch(size_ch), .size_val(size_val),
    .full(full), .empty(empty), .done_irq(done_irq), .ovf_err(ovf_err),
    .udf_err(udf_err), .irq_clr(irq_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per channel plus flag/counter bookkeeping.
  logic [DW-1:0] mq [NCH][$];
  bit            m_mode [NCH];
  int            m_size [NCH];
  int            m_xfer [NCH];
  bit [NCH-1:0]  m_done, m_ovf, m_udf;
  logic [DW-1:0] m_ardata, m_prdata;
  bit            m_arvalid, m_prvalid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tx, pu, po, phy_hit, setd, sovf, sudf;
    int n;
    logic [DW-1:0] w;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_mode[c] = 0; m_size[c] = 0; m_xfer[c] = 0;
      end
      m_done = '0; m_ovf = '0; m_udf = '0;
      m_ardata = '0; m_prdata = '0; m_arvalid = 0; m_prvalid = 0;
      return;
    end
    m_arvalid = 0;
    m_prvalid = 0;
    for (int c = 0; c < NCH; c++) begin
      setd = 0; sovf = 0; sudf = 0; phy_hit = 0;
      tx = m_mode[c];
      n  = mq[c].size();
      if (ch_mode[c] != m_mode[c]) begin
        mq[c].delete();
        m_xfer[c] = 0;
        m_mode[c] = ch_mode[c];
      end else begin
        pu = tx ? (ahb_wr_en && ahb_ch == c) : (phy_we && phy_ch == c);
        po = tx ? (phy_re && phy_ch == c) : (ahb_rd_en && ahb_ch == c);
        if (po) begin
          if (n > 0) begin
            w = mq[c].pop_front();
            if (tx) begin m_prdata = w; m_prvalid = 1; phy_hit = 1; end
            else begin m_ardata = w; m_arvalid = 1; end
          end else sudf = 1;
        end
        if (pu) begin
          if (n < DEP) begin
            mq[c].push_back(tx ? ahb_wdata : phy_wdata);
            if (!tx) phy_hit = 1;
          end else sovf = 1;
        end
        if (phy_hit && m_size[c] != 0) begin
          m_xfer[c]++;
          if (m_xfer[c] == m_size[c]) begin m_xfer[c] = 0; setd = 1; end
        end
      end
      if (size_wr && size_ch == c) begin m_size[c] = int'(size_val); m_xfer[c] = 0; end
      m_done[c] = (m_done[c] && !irq_clr[c]) || setd;
      m_ovf[c]  = (m_ovf[c] && !irq_clr[c]) || sovf;
      m_udf[c]  = (m_udf[c] && !irq_clr[c]) || sudf;
    end
  endtask

  task automatic compare_all();
    bit [NCH-1:0] ef, ee;
    for (int c = 0; c < NCH; c++) begin
      ef[c] = (mq[c].size() == DEP);
      ee[c] = (mq[c].size() == 0);
    end
    chk("full", full, ef);
    chk("empty", empty, ee);
    chk("done_irq", done_irq, m_done);
    chk("ovf_err", ovf_err, m_ovf);
    chk("udf_err", udf_err, m_udf);
    chk("ahb_level", ahb_level, mq[ahb_ch].size());
    chk("ahb_rvalid", ahb_rvalid, m_arvalid);
    chk("phy_rvalid", phy_rvalid, m_prvalid);
    chk("ahb_rdata", ahb_rdata, m_ardata);
    chk("phy_rdata", phy_rdata, m_prdata);
  endtask

  task automatic step();
    model_edge();
    @(posedge hclk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    ahb_wr_en = 0; ahb_rd_en = 0; phy_we = 0; phy_re = 0;
    size_wr = 0; irq_clr = '0;
  endtask

  typedef struct packed {
    logic        ahb_rd;
    logic        ahb_wr;
    logic        phy_wr;
    logic [31:0] wdata;
    logic [3:0]  clr;
    logic [8:0]  e_level;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_udf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; ch_mode = '0; ahb_ch = '0; phy_ch = '0; size_ch = '0;
    ahb_wdata = '0; phy_wdata = '0; size_val = '0;
    clear_in();
    step();
    step();
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 4'h0);
    chk("rst_rvalid", {ahb_rvalid, phy_rvalid}, 2'b00);
    chk("rst_rdata", {ahb_rdata, phy_rdata}, 64'h0);
    chk("rst_flags", {done_irq, ovf_err, udf_err}, 12'h0);
    reset = 0;
    step();

    // Table: channel 3 in RX mode, PHY pushes, AHB pops, one wrong-side AHB push.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'hA1, 4'h0, 9'd1, 1'b0, 32'h0,  1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'hA2, 4'h0, 9'd2, 1'b0, 32'h0,  1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 9'd1, 1'b1, 32'hA1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'hA3, 4'h0, 9'd1, 1'b1, 32'hA2, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'hFF, 4'h0, 9'd1, 1'b0, 32'hA2, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 9'd0, 1'b1, 32'hA3, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 9'd0, 1'b0, 32'hA3, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'hA4, 4'h0, 9'd1, 1'b0, 32'hA3, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  4'h8, 9'd1, 1'b0, 32'hA3, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0,  4'h0, 9'd0, 1'b1, 32'hA4, 1'b0};
    ahb_ch = 2'd3; phy_ch = 2'd3;
    for (int i = 0; i < 10; i++) begin
      ahb_rd_en = tbl[i].ahb_rd; ahb_wr_en = tbl[i].ahb_wr; phy_we = tbl[i].phy_wr;
      phy_wdata = tbl[i].wdata; ahb_wdata = tbl[i].wdata; irq_clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_level", i), ahb_level, tbl[i].e_level);
      chk($sformatf("tbl%0d_rvalid", i), ahb_rvalid, tbl[i].e_rvalid);
      chk($sformatf("tbl%0d_rdata", i), ahb_rdata, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_udf", i), udf_err[3], tbl[i].e_udf);
    end
    clear_in();

    // Fill TX channel 0 to the brim, overflow once, then drain through the PHY side.
    ch_mode = 4'b0001; ahb_ch = 0; phy_ch = 0;
    step();
    chk("flush_empty0", empty[0], 1'b1);
    ahb_wr_en = 1;
    for (int i = 0; i < DEP; i++) begin
      ahb_wdata = 32'h1000 + i;
      step();
    end
    chk("fill_full0", full[0], 1'b1);
    ahb_wdata = 32'hDEAD;
    step();
    chk("ovf0", ovf_err[0], 1'b1);
    chk("ovf_level", ahb_level, 9'd256);
    clear_in(); irq_clr = 4'b0001; step(); clear_in();
    phy_re = 1;
    for (int i = 0; i < DEP; i++) begin
      step();
      chk("drain_rvalid", phy_rvalid, 1'b1);
      chk("drain_data", phy_rdata, 32'h1000 + i);
    end
    clear_in();
    step();
    chk("drain_empty0", empty[0], 1'b1);
    chk("drain_rvalid_off", phy_rvalid, 1'b0);

    // RX channel 2 with a 16-word transfer size.
    size_wr = 1; size_ch = 2; size_val = 9'd16; phy_ch = 2; ahb_ch = 2;
    step(); clear_in();
    for (int r = 0; r < 2; r++) begin
      phy_we = 1;
      for (int i = 0; i < 16; i++) begin
        phy_wdata = 32'h2000 + 16 * r + i;
        step();
        if (i >= 14) chk("done2", done_irq[2], (i == 15));
      end
      clear_in(); irq_clr = 4'b0100; step(); clear_in();
      chk("done2_clr", done_irq[2], 1'b0);
    end
    ahb_rd_en = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("rx2_data", ahb_rdata, 32'h2000 + i);
    end
    step();
    chk("udf2", udf_err[2], 1'b1);
    chk("udf2_rvalid", ahb_rvalid, 1'b0);
    clear_in(); irq_clr = 4'b0100; step(); clear_in();

    // Pointer wrap on RX channel 1: alternate push and pop 600 times.
    ahb_ch = 1; phy_ch = 1;
    for (int i = 0; i < 600; i++) begin
      clear_in(); phy_we = 1; phy_wdata = 32'h3000 + i;
      step();
      chk("wrap_level1", ahb_level, 9'd1);
      clear_in(); ahb_rd_en = 1;
      step();
      chk("wrap_data", ahb_rdata, 32'h3000 + i);
      chk("wrap_level0", ahb_level, 9'd0);
    end
    clear_in();

    // Push+pop at full and at empty on TX channel 0.
    ahb_ch = 0; phy_ch = 0; ahb_wr_en = 1;
    for (int i = 0; i < DEP; i++) begin
      ahb_wdata = $urandom;
      step();
    end
    phy_re = 1;
    step();
    chk("pp_full_rvalid", phy_rvalid, 1'b1);
    chk("pp_full_ovf", ovf_err[0], 1'b1);
    chk("pp_full_level", ahb_level, 9'd255);
    clear_in(); irq_clr = 4'b0001; phy_re = 1;
    for (int i = 0; i < DEP - 1; i++) begin
      step();
      irq_clr = '0;
    end
    clear_in(); ahb_wr_en = 1; phy_re = 1; ahb_wdata = 32'h5555;
    step();
    chk("pp_empty_level", ahb_level, 9'd1);
    chk("pp_empty_udf", udf_err[0], 1'b1);
    chk("pp_empty_rvalid", phy_rvalid, 1'b0);
    clear_in(); irq_clr = 4'b0001; phy_re = 1; step(); clear_in();

    // Concurrent sides, wrong-side push, and a mode toggle with data held.
    ahb_ch = 0; phy_ch = 3;
    for (int i = 0; i < 4; i++) begin
      ahb_wr_en = 1; ahb_wdata = 32'h4000 + i; phy_we = 1; phy_wdata = 32'h4100 + i;
      step();
      chk("conc_level0", ahb_level, i + 1);
    end
    clear_in(); ahb_ch = 3; ahb_wr_en = 1; ahb_wdata = 32'hBAD;
    step();
    chk("wrong_side_level", ahb_level, 9'd4);
    chk("wrong_side_flags", {ovf_err[3], udf_err[3]}, 2'b00);
    clear_in(); ahb_ch = 0; ahb_wr_en = 1; ahb_wdata = 32'h4004;
    step();
    chk("held5", ahb_level, 9'd5);
    ch_mode = 4'b0000; ahb_wdata = 32'h4005;
    step();
    chk("toggle_level", ahb_level, 9'd0);
    chk("toggle_ovf", ovf_err[0], 1'b0);
    clear_in(); step();

    // Reset in the middle of a PHY pop burst.
    ch_mode = 4'b0001; step();
    ahb_ch = 0; phy_ch = 0; ahb_wr_en = 1;
    for (int i = 0; i < 6; i++) begin ahb_wdata = 32'h6000 + i; step(); end
    clear_in(); phy_re = 1;
    for (int i = 0; i < 3; i++) step();
    reset = 1;
    step();
    chk("rst_mid_rvalid", phy_rvalid, 1'b0);
    chk("rst_mid_rdata", phy_rdata, 32'h0);
    chk("rst_mid_empty", empty, 4'hF);
    chk("rst_mid_flags", {done_irq, ovf_err, udf_err, full}, 16'h0);
    reset = 0; clear_in();
    step();

    // Randomized traffic checked cycle by cycle against the queue model.
    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = (i < 1500) ? 70 : 30;
      if ($urandom_range(199) == 0) ch_mode[$urandom_range(NCH - 1)] ^= 1'b1;
      ahb_ch    = CW'($urandom_range(NCH - 1));
      phy_ch    = CW'($urandom_range(NCH - 1));
      ahb_wr_en = ($urandom_range(99) < pw);
      phy_we    = ($urandom_range(99) < pw);
      ahb_rd_en = ($urandom_range(99) >= pw);
      phy_re    = ($urandom_range(99) >= pw);
      ahb_wdata = $urandom;
      phy_wdata = $urandom;
      size_wr   = ($urandom_range(49) == 0);
      size_ch   = CW'($urandom_range(NCH - 1));
      size_val  = (AW + 1)'($urandom_range(8));
      irq_clr   = ($urandom_range(7) == 0) ? NCH'($urandom) : '0;
      reset     = ($urandom_range(999) == 0);
      step();
    end
    reset = 0; clear_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
